// File: rtl/transferstb_pkg.sv
// Shared definitions for the strobe-to-handshake engine: channel state encoding
// and the default ack synchroniser depth.
package transferstb_pkg;

   localparam int NFF_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      RELEASE = 2'b10
   } chan_state_e;

endpackage

// File: rtl/transferstb_req_if.sv
// Strobe/handshake bundle between producer logic, the engine and the foreign domain.
// master = the engine side, slave = everything that drives strobes and acks.
interface transferstb_req_if #(
   parameter int NCH = 4,
   parameter int CW  = 8
);

   logic [NCH-1:0]    i_stb;
   logic [NCH-1:0]    o_req;
   logic [NCH-1:0]    i_ack;
   logic [NCH-1:0]    o_busy;
   logic [NCH-1:0]    o_done;
   logic              i_clr_drops;
   logic [NCH*CW-1:0] o_drops;

   modport master (
      input  i_stb, i_ack, i_clr_drops,
      output o_req, o_busy, o_done, o_drops
   );

   modport slave (
      output i_stb, i_ack, i_clr_drops,
      input  o_req, o_busy, o_done, o_drops
   );

endinterface

// File: rtl/transferstb_chan.sv
// One strobe channel: ack synchroniser, four-phase req FSM, pending flag and,
// with TRANSFERSTB_COUNT_EN defined, a saturating dropped-strobe counter.
module transferstb_chan
   import transferstb_pkg::*;
#(
   parameter int NFF = NFF_DEFAULT
`ifdef TRANSFERSTB_COUNT_EN
   ,
   parameter int CW  = 8
`endif
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_stb,
   input  logic          i_ack,
   output logic          o_req,
   output logic          o_busy,
   output logic          o_done
`ifdef TRANSFERSTB_COUNT_EN
   ,
   input  logic          i_clr_drops,
   output logic [CW-1:0] o_drops
`endif
);

   logic [NFF-1:0] ack_sync;
   logic           ack_s;
   chan_state_e    state_q, state_d;
   logic           pend_q, pend_d;

   assign ack_s = ack_sync[NFF-1];

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ack_sync <= '0;
         state_q  <= IDLE;
         pend_q   <= 1'b0;
      end else begin
         ack_sync <= {ack_sync[NFF-2:0], i_ack};
         state_q  <= state_d;
         pend_q   <= pend_d;
      end
   end

   // NOTE: every output of this block gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      o_done  = 1'b0;
      case (state_q)
         IDLE: begin
            // A high ack_s here is left over from a reset mid-handshake.
            if (i_stb || pend_q) begin
               if (!ack_s) begin
                  state_d = REQ;
                  pend_d  = 1'b0;
               end else begin
                  pend_d  = 1'b1;
               end
            end
         end
         REQ: begin
            if (i_stb) pend_d = 1'b1;
            if (ack_s) state_d = RELEASE;
         end
         RELEASE: begin
            if (!ack_s) begin
               o_done = 1'b1;
               if (i_stb || pend_q) begin
                  state_d = REQ;
                  pend_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (i_stb) begin
               pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_req  = (state_q == REQ);
   assign o_busy = (state_q != IDLE) || pend_q;

`ifdef TRANSFERSTB_COUNT_EN
   // A strobe is lost whenever one is already waiting, including the cycle the
   // waiting one is consumed.
   logic          drop;
   logic [CW-1:0] drops_q;

   assign drop = i_stb && pend_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         drops_q <= '0;
      end else if (i_clr_drops) begin
         drops_q <= CW'(drop);
      end else if (drop && (drops_q != '1)) begin
         drops_q <= drops_q + 1'b1;
      end
   end

   assign o_drops = drops_q;
`endif

endmodule

// File: rtl/transferstb_req.sv
// Multi-channel strobe-to-four-phase-handshake engine, one transferstb_chan per
// channel. Drop counters exist only when TRANSFERSTB_COUNT_EN is defined.
module transferstb_req
   import transferstb_pkg::*;
#(
   parameter int NCH = 4,
   parameter int NFF = NFF_DEFAULT,
   parameter int CW  = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   transferstb_req_if.master bus
);

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      transferstb_chan #(
         .NFF (NFF)
`ifdef TRANSFERSTB_COUNT_EN
         ,
         .CW  (CW)
`endif
      ) u_chan (
         .i_clk       (i_clk),
         .i_reset     (i_reset),
         .i_stb       (bus.i_stb[k]),
         .i_ack       (bus.i_ack[k]),
         .o_req       (bus.o_req[k]),
         .o_busy      (bus.o_busy[k]),
         .o_done      (bus.o_done[k])
`ifdef TRANSFERSTB_COUNT_EN
         ,
         .i_clr_drops (bus.i_clr_drops),
         .o_drops     (bus.o_drops[k*CW +: CW])
`endif
      );
   end

`ifndef TRANSFERSTB_COUNT_EN
   assign bus.o_drops = {(NCH*CW){1'b0}};
`endif

endmodule
